// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl
//   EX-stage initiator for the iterative multiply/divide unit. Detects
//   M-extension ops, latches operands/controls and pulses the matching start.
//   It stalls the pipeline until the unit reports done, or until a timeout.
//   It then presents the captured result for one cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   i_valid, i_flush         EX instruction valid / killed
//   i_ALU_Sel                decoded select (1010 MUL, 1011 MULH, 1100 DIV, 1101 REM)
//   i_A, i_B                 forwarded operands
//   i_Unsigned, i_HSU        signedness controls
//   o_ctrl_ALU_Sel, o_A, o_B, o_ctrl_Unsigned, o_ctrl_HSU
//                            latched op presented to the ALU
//   o_ctrl_Start_Mul/Div     single-cycle start pulses
//   i_ctrl_Done              ALU combined done
//   i_ALU_Result             ALU result for the latched select
//   o_stall                  freeze IF/ID/EX
//   o_Result, o_Result_Valid captured result and its one-cycle valid
//   o_Err                    one-cycle timeout flag
//
// Optional feature: define MULDIV_REUSE_EN to reuse the last completed result
// when an identical op arrives. In that case the op skips the unit handshake.
module muldiv_issue_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [3:0]            i_ALU_Sel,
  input  logic [DATA_WIDTH-1:0] i_A,
  input  logic [DATA_WIDTH-1:0] i_B,
  input  logic                  i_Unsigned,
  input  logic                  i_HSU,
  output logic [3:0]            o_ctrl_ALU_Sel,
  output logic [DATA_WIDTH-1:0] o_A,
  output logic [DATA_WIDTH-1:0] o_B,
  output logic                  o_ctrl_Unsigned,
  output logic                  o_ctrl_HSU,
  output logic                  o_ctrl_Start_Mul,
  output logic                  o_ctrl_Start_Div,
  input  logic                  i_ctrl_Done,
  input  logic [DATA_WIDTH-1:0] i_ALU_Result,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic                  o_Result_Valid,
  output logic                  o_Err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] SEL_FIRST = 4'b1010;
  localparam logic [3:0] SEL_LAST  = 4'b1101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            lat_sel;
  logic [DATA_WIDTH-1:0] lat_a;
  logic [DATA_WIDTH-1:0] lat_b;
  logic                  lat_uns;
  logic                  lat_hsu;
  logic [DATA_WIDTH-1:0] result;
  logic                  err_flag;

  logic is_m;
  logic issue;
  logic done_ok;
  logic timeout;
  logic unit_end;
  logic reuse_hit;

  // Op detection and completion qualifiers. Done is ignored while cnt is 0
  // because the unit may still show its idle-done level right after start.
  always_comb begin
    is_m     = i_valid & (i_ALU_Sel >= SEL_FIRST) & (i_ALU_Sel <= SEL_LAST);
    issue    = is_m & ~i_flush;
    done_ok  = i_ctrl_Done & (cnt != CNT_ZERO);
    timeout  = ~done_ok & (cnt == CNT_LAST);
    unit_end = done_ok | timeout;
  end

`ifdef MULDIV_REUSE_EN
  // The latched op and captured result double as the cache key and data.
  // Only a valid bit is needed on top of them.
  logic cache_valid;

  assign reuse_hit = issue & cache_valid & (i_ALU_Sel == lat_sel) &
                     (i_A == lat_a) & (i_B == lat_b) &
                     (i_Unsigned == lat_uns) & (i_HSU == lat_hsu);

  // Cache valid: set on a clean completion, dropped on timeout or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
    end else begin
      case (state)
        START: if (i_flush) cache_valid <= 1'b0;
        WAIT: begin
          if (i_flush | timeout) cache_valid <= 1'b0;
          else if (done_ok)      cache_valid <= 1'b1;
        end
        default: cache_valid <= cache_valid;
      endcase
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  // Issue FSM with operand latches, wait counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      lat_sel  <= 4'b0000;
      lat_a    <= {DATA_WIDTH{1'b0}};
      lat_b    <= {DATA_WIDTH{1'b0}};
      lat_uns  <= 1'b0;
      lat_hsu  <= 1'b0;
      result   <= {DATA_WIDTH{1'b0}};
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            lat_sel <= i_ALU_Sel;
            lat_a   <= i_A;
            lat_b   <= i_B;
            lat_uns <= i_Unsigned;
            lat_hsu <= i_HSU;
            if (reuse_hit) begin
              err_flag <= 1'b0;
              state    <= DONE;
            end else begin
              state <= START;
            end
          end
        end
        START: begin
          cnt   <= CNT_ZERO;
          state <= i_flush ? DRAIN : WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_ONE;
          if (unit_end) begin
            // A flush on the completing cycle simply absorbs the result.
            if (i_flush) begin
              state <= IDLE;
            end else begin
              result   <= done_ok ? i_ALU_Result : {DATA_WIDTH{1'b0}};
              err_flag <= timeout;
              state    <= DONE;
            end
          end else if (i_flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          cnt <= cnt + CNT_ONE;
          if (unit_end) state <= IDLE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall: combinational detect in IDLE, held through the handshake, and in
  // DRAIN only a new M op is held back.
  always_comb begin
    case (state)
      IDLE:    o_stall = issue;
      START:   o_stall = 1'b1;
      WAIT:    o_stall = 1'b1;
      DRAIN:   o_stall = is_m;
      DONE:    o_stall = 1'b0;
      default: o_stall = 1'b0;
    endcase
  end

  assign o_ctrl_ALU_Sel   = lat_sel;
  assign o_A              = lat_a;
  assign o_B              = lat_b;
  assign o_ctrl_Unsigned  = lat_uns;
  assign o_ctrl_HSU       = lat_hsu;
  // Select bit 2 distinguishes DIV/REM from MUL/MULH.
  assign o_ctrl_Start_Mul = (state == START) & ~lat_sel[2];
  assign o_ctrl_Start_Div = (state == START) &  lat_sel[2];
  assign o_Result         = result;
  assign o_Result_Valid   = (state == DONE) & ~i_flush;
  assign o_Err            = (state == DONE) & err_flag & ~i_flush;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
module tb_muldiv_issue_ctrl;
  localparam int DW    = 32;
  localparam int TO    = 8;
  localparam int N_OPS = 120;
`ifdef MULDIV_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic        hsu;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  logic i_valid, i_flush, i_Unsigned, i_HSU, i_ctrl_Done;
  logic [3:0] i_ALU_Sel, o_ctrl_ALU_Sel;
  logic [DW-1:0] i_A, i_B, i_ALU_Result, o_A, o_B, o_Result;
  logic o_ctrl_Unsigned, o_ctrl_HSU, o_ctrl_Start_Mul, o_ctrl_Start_Div;
  logic o_stall, o_Result_Valid, o_Err;

  int n_cmp = 0;
  int n_bad = 0;

  op_t         cache_op;
  bit          cache_v = 1'b0;
  logic [31:0] cache_res;

  op_t ops [N_OPS];
  int  ks  [N_OPS];
  int  fs  [N_OPS];
  bit  dms [N_OPS];

  muldiv_issue_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_ALU_Sel(i_ALU_Sel), .i_A(i_A), .i_B(i_B),
    .i_Unsigned(i_Unsigned), .i_HSU(i_HSU),
    .o_ctrl_ALU_Sel(o_ctrl_ALU_Sel), .o_A(o_A), .o_B(o_B),
    .o_ctrl_Unsigned(o_ctrl_Unsigned), .o_ctrl_HSU(o_ctrl_HSU),
    .o_ctrl_Start_Mul(o_ctrl_Start_Mul), .o_ctrl_Start_Div(o_ctrl_Start_Div),
    .i_ctrl_Done(i_ctrl_Done), .i_ALU_Result(i_ALU_Result),
    .o_stall(o_stall), .o_Result(o_Result), .o_Result_Valid(o_Result_Valid),
    .o_Err(o_Err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension reference for the value the ALU would return.
  function automatic logic [31:0] alu_ref(input op_t op);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(op.a));
    sb = longint'($signed(op.b));
    ua = longint'({32'd0, op.a});
    ub = longint'({32'd0, op.b});
    case (op.sel)
      4'b1010: begin p = ua * ub; return p[31:0]; end
      4'b1011: begin
        if (op.uns)      p = ua * ub;
        else if (op.hsu) p = sa * ub;
        else             p = sa * sb;
        return p[63:32];
      end
      4'b1100: begin
        if (op.b == 32'd0) return 32'hFFFF_FFFF;
        if (op.uns) return op.a / op.b;
        if (op.a == 32'h8000_0000 && op.b == 32'hFFFF_FFFF) return op.a;
        p = sa / sb; return p[31:0];
      end
      4'b1101: begin
        if (op.b == 32'd0) return op.a;
        if (op.uns) return op.a % op.b;
        if (op.a == 32'h8000_0000 && op.b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_m_ref(input logic v, input logic [3:0] sel);
    return v && (sel >= 4'd10) && (sel <= 4'd13);
  endfunction

  function automatic op_t mk_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                input logic uns, input logic hsu);
    op_t o;
    o.sel = sel; o.a = a; o.b = b; o.uns = uns; o.hsu = hsu;
    return o;
  endfunction

  task automatic drive_op(input op_t op, input bit flush);
    i_valid = 1'b1; i_flush = flush; i_ALU_Sel = op.sel;
    i_A = op.a; i_B = op.b; i_Unsigned = op.uns; i_HSU = op.hsu;
  endtask

  // Non-M traffic: either an invalid slot (any select) or a valid non-M op.
  task automatic drive_filler();
    int r;
    i_valid = 1'($urandom % 2);
    r = $urandom % 12;
    if (i_valid) i_ALU_Sel = (r < 10) ? 4'(r) : 4'(r + 4);
    else         i_ALU_Sel = 4'($urandom % 16);
    i_flush = 1'($urandom % 2);
    i_A = $urandom; i_B = $urandom;
    i_Unsigned = 1'($urandom % 2); i_HSU = 1'($urandom % 2);
    i_ctrl_Done = 1'($urandom % 2); i_ALU_Result = $urandom;
  endtask

  task automatic check_outs(input int c, input bit e_stall, input bit e_smul, input bit e_sdiv,
                            input bit e_valid, input bit e_err, input logic [31:0] e_res);
    check_val($sformatf("stall c%0d", c), o_stall, e_stall);
    check_val($sformatf("start_mul c%0d", c), o_ctrl_Start_Mul, e_smul);
    check_val($sformatf("start_div c%0d", c), o_ctrl_Start_Div, e_sdiv);
    check_val($sformatf("result_valid c%0d", c), o_Result_Valid, e_valid);
    check_val($sformatf("err c%0d", c), o_Err, e_err);
    if (e_valid) check_val($sformatf("result c%0d", c), o_Result, e_res);
  endtask

  // One M op from its detect cycle (c=0) until the controller is idle again.
  // The unit finishes at a cycle fixed by the done schedule alone; a flush
  // before then only decides whether a DONE cycle follows.
  task automatic run_episode(input op_t op, input int k, input int f, input op_t nxt,
                             input bit dm, output bit held);
    logic [31:0] exp_r;
    int acc, end_c, done_c, last;
    bit tmo, fb, dn, in_drain, e_stall, e_valid, is_div;
    exp_r  = alu_ref(op);
    is_div = op.sel[2];
    held   = 1'b0;
    if (f == 0) begin
      drive_op(op, 1'b1);
      i_ctrl_Done = 1'($urandom % 2); i_ALU_Result = $urandom;
      @(negedge clk);
      check_outs(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (REUSE && cache_v && (op == cache_op)) begin
      drive_op(op, 1'b0);
      i_ctrl_Done = 1'($urandom % 2); i_ALU_Result = $urandom;
      @(negedge clk);
      check_outs(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      drive_op(op, f == 1);
      i_ctrl_Done = 1'($urandom % 2); i_ALU_Result = $urandom;
      @(negedge clk);
      check_outs(1, 1'b0, 1'b0, 1'b0, f != 1, 1'b0, cache_res);
      @(posedge clk); #1;
      return;
    end
    // Start at c=1, first WAIT at c=2 (count 0), done accepted from c=3 on.
    acc    = (k < 0) ? 1000 : ((k + 1 > 3) ? k + 1 : 3);
    tmo    = acc > TO + 1;
    end_c  = tmo ? TO + 1 : acc;
    done_c = end_c + 1;
    fb     = (f >= 1) && (f <= end_c);
    last   = fb ? end_c : done_c;
    for (int c = 0; c <= last; c++) begin
      in_drain = fb && (c > f);
      if (in_drain) begin
        if (dm) drive_op(nxt, 1'b0);
        else    drive_filler();
      end else begin
        drive_op(op, c == f);
      end
      dn = (k < 0) ? 1'b0 : ((k == 0) ? 1'b1 : (c >= k + 1));
      i_ctrl_Done  = dn;
      i_ALU_Result = dn ? exp_r : $urandom;
      e_stall = (c == done_c) ? 1'b0 : (in_drain ? is_m_ref(i_valid, i_ALU_Sel) : 1'b1);
      e_valid = (c == done_c) && (f != done_c);
      @(negedge clk);
      check_outs(c, e_stall, (c == 1) && !is_div, (c == 1) && is_div,
                 e_valid, e_valid && tmo, tmo ? 32'd0 : exp_r);
      if (c >= 1 && c <= end_c) begin
        check_val($sformatf("o_A c%0d", c), o_A, op.a);
        check_val($sformatf("o_B c%0d", c), o_B, op.b);
        check_val($sformatf("o_sel c%0d", c), o_ctrl_ALU_Sel, op.sel);
        check_val($sformatf("o_uns c%0d", c), o_ctrl_Unsigned, op.uns);
        check_val($sformatf("o_hsu c%0d", c), o_ctrl_HSU, op.hsu);
      end
      @(posedge clk); #1;
    end
    if (fb || tmo) begin
      cache_v = 1'b0;
    end else begin
      cache_v = 1'b1; cache_op = op; cache_res = exp_r;
    end
    held = fb && dm;
  endtask

  task automatic run_gap(input int g);
    for (int j = 0; j < g; j++) begin
      drive_filler();
      @(negedge clk);
      check_outs(100 + j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted mid-WAIT: everything must clear without a clock edge.
  task automatic reset_test();
    op_t op;
    op = mk_op(4'b1100, 32'd50, 32'd5, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive_op(op, 1'b0); i_ctrl_Done = 1'b0; i_ALU_Result = $urandom;
      if (c < 3) begin
        @(negedge clk);
        check_outs(c, 1'b1, 1'b0, c == 1, 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
      end
    end
    #2;
    rst = 1'b1; i_valid = 1'b0;
    #1;
    check_val("rst stall", o_stall, 1'b0);
    check_val("rst start_mul", o_ctrl_Start_Mul, 1'b0);
    check_val("rst start_div", o_ctrl_Start_Div, 1'b0);
    check_val("rst result_valid", o_Result_Valid, 1'b0);
    check_val("rst err", o_Err, 1'b0);
    check_val("rst result", o_Result, 32'd0);
    check_val("rst o_A", o_A, 32'd0);
    check_val("rst o_B", o_B, 32'd0);
    check_val("rst sel", o_ctrl_ALU_Sel, 4'd0);
    check_val("rst uns", o_ctrl_Unsigned, 1'b0);
    check_val("rst hsu", o_ctrl_HSU, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cache_v = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      i_valid = 1'b0; i_ctrl_Done = 1'($urandom % 2);
      @(negedge clk);
      check_outs(200 + j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit held;
    int r;
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ALU_Sel = 4'd0;
    i_A = 32'd0; i_B = 32'd0; i_Unsigned = 1'b0; i_HSU = 1'b0;
    i_ctrl_Done = 1'b0; i_ALU_Result = 32'd0;
    #2;
    check_outs(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("reset result", o_Result, 32'd0);
    check_val("reset o_A", o_A, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    ops[0] = mk_op(4'b1010, 32'd7, 32'd6, 1'b0, 1'b0);      ks[0] = 3;  fs[0] = -1; dms[0] = 1'b0;
    ops[1] = mk_op(4'b1100, 32'd100, 32'd7, 1'b0, 1'b0);    ks[1] = 0;  fs[1] = -1; dms[1] = 1'b0;
    ops[2] = mk_op(4'b1101, 32'd12345, 32'h77, 1'b0, 1'b0); ks[2] = -1; fs[2] = -1; dms[2] = 1'b0;
    ops[3] = mk_op(4'b1100, 32'd1000, 32'd3, 1'b1, 1'b0);   ks[3] = 5;  fs[3] = 3;  dms[3] = 1'b1;
    ops[4] = mk_op(4'b1010, 32'd3, 32'd5, 1'b0, 1'b0);      ks[4] = 2;  fs[4] = -1; dms[4] = 1'b0;
    ops[5] = mk_op(4'b1011, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0); ks[5] = 2; fs[5] = -1; dms[5] = 1'b0;
    ops[6] = ops[5];                                        ks[6] = 2;  fs[6] = -1; dms[6] = 1'b0;
    for (int i = 7; i < N_OPS; i++) begin
      if (i == 7 || ($urandom % 3) == 0) ops[i] = ops[i-1];
      else ops[i] = mk_op(4'(10 + ($urandom % 4)), ($urandom % 2) ? $urandom : 32'($urandom % 64),
                          $urandom % 50, 1'($urandom % 2), 1'($urandom % 2));
      r = $urandom % 10;
      ks[i]  = (r < 2) ? -1 : int'($urandom_range(0, 10));
      fs[i]  = ($urandom % 2) ? -1 : int'($urandom_range(0, TO + 3));
      dms[i] = (i == N_OPS - 1) ? 1'b0 : 1'($urandom % 2);
    end

    for (int i = 0; i < 7; i++) begin
      run_episode(ops[i], ks[i], fs[i], ops[i+1], dms[i], held);
    end
    reset_test();
    for (int i = 7; i < N_OPS; i++) begin
      run_episode(ops[i], ks[i], fs[i], (i < N_OPS - 1) ? ops[i+1] : ops[i], dms[i], held);
      if (!held) run_gap($urandom % 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
